// File: rtl/aes_bridge_pkg.sv
// Shared types and constants for the AES word-serial load bridge.
package aes_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] KEY_W0 = 3'd0;
    localparam logic [2:0] PT_W0  = 3'd4;

    localparam logic [7:0] MASK_FULL = 8'hFF;
    localparam logic [7:0] MASK_KEY  = 8'h0F;

endpackage

// File: rtl/aes_word_regs.sv
// Eight 32-bit operand words (key 0-3, plaintext 4-7) with a per-word valid mask.
// Word 0 of each operand lands in the most significant 32 bits.
module aes_word_regs
    import aes_bridge_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [2:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         clear_pt,
    output logic [7:0]   mask,
    output logic [127:0] key,
    output logic [127:0] pt
);

    logic [31:0] words [8];

    // NOTE: the operand words are reset along with the mask so key/pt
    // outputs read as zero after reset; this is a small register file, not a RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                words[i] <= '0;
            end
            mask <= '0;
        end else begin
            if (clear_pt) begin
                mask <= mask & MASK_KEY;
            end
            if (wr_en) begin
                words[wr_addr] <= wr_data;
                mask[wr_addr]  <= 1'b1;
            end
        end
    end

    assign key = {words[KEY_W0], words[KEY_W0 + 3'd1], words[KEY_W0 + 3'd2], words[KEY_W0 + 3'd3]};
    assign pt  = {words[PT_W0],  words[PT_W0 + 3'd1],  words[PT_W0 + 3'd2],  words[PT_W0 + 3'd3]};

endmodule

// File: rtl/aes_load_bridge.sv
// Word-serial front end for the AES core: assembles operands, launches the core,
// waits for completion with a timeout and holds the ciphertext for readback.
module aes_load_bridge
    import aes_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [2:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         err_incomplete,
    output logic         err_timeout,
    input  logic [1:0]   rd_idx,
    output logic [31:0]  rd_data,
    output logic [127:0] key_out,
    output logic [127:0] pt_out,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_dout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [127:0]    result;
    logic [7:0]      mask;
    logic            wr_en;
    logic            accept;
    logic            reject;
    logic            capture;
    logic            expire;

    assign wr_ready   = (state == IDLE) & ~start;
    assign wr_en      = wr_valid & wr_ready;
    assign busy       = (state != IDLE);
    assign core_start = (state == START);

    aes_word_regs u_regs (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clear_pt (accept),
        .mask     (mask),
        .key      (key_out),
        .pt       (pt_out)
    );

    // NOTE: state and flags use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mask == MASK_FULL) begin
                        accept  = 1'b1;
                        state_d = START;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                // Completion on the timeout edge still counts as a good run.
                if (core_done) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            result         <= '0;
            done           <= 1'b0;
            err_incomplete <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            if (state == START) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                done           <= 1'b0;
                err_incomplete <= 1'b0;
                err_timeout    <= 1'b0;
            end
            if (reject) begin
                err_incomplete <= 1'b1;
            end
            if (capture) begin
                result <= core_dout;
                done   <= 1'b1;
            end
            if (expire) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // Index 0 selects the most significant word.
    assign rd_data = result[{~rd_idx, 5'd0} +: 32];

endmodule

// File: tb/tb_aes_load_bridge.sv
// Randomized self-checking bench for aes_load_bridge with a word-level operand
// model and a mock AES core driven from the stimulus tasks.
module tb_aes_load_bridge;

    localparam int TO = 255;

    logic         clock;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [2:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         start;
    logic         busy;
    logic         done;
    logic         err_incomplete;
    logic         err_timeout;
    logic [1:0]   rd_idx;
    logic [31:0]  rd_data;
    logic [127:0] key_out;
    logic [127:0] pt_out;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_dout;

    aes_load_bridge #(.TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err_incomplete (err_incomplete),
        .err_timeout    (err_timeout),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
        .key_out        (key_out),
        .pt_out         (pt_out),
        .core_start     (core_start),
        .core_done      (core_done),
        .core_dout      (core_dout)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: operand words, their valid bits, result words and flags.
    logic [31:0] m_word [8];
    bit          m_valid [8];
    logic [31:0] m_res [4];
    bit          m_done, m_inc, m_to;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_word[i]  = '0;
            m_valid[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) m_res[i] = '0;
        m_done = 0;
        m_inc  = 0;
        m_to   = 0;
    endtask

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < 8; i++) f &= m_valid[i];
        return f;
    endfunction

    function automatic logic [127:0] model_key();
        return {m_word[0], m_word[1], m_word[2], m_word[3]};
    endfunction

    function automatic logic [127:0] model_pt();
        return {m_word[4], m_word[5], m_word[6], m_word[7]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".done"}, done, m_done);
        check({tag, ".err_incomplete"}, err_incomplete, m_inc);
        check({tag, ".err_timeout"}, err_timeout, m_to);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".key_out"}, key_out, model_key());
        check({tag, ".pt_out"}, pt_out, model_pt());
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1 check($sformatf("%s.rd_data[%0d]", tag, i), rd_data, m_res[i]);
        end
    endtask

    task automatic write_word(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clock);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        #1 check("wr_ready_idle", wr_ready, 1);
        @(negedge clock);
        wr_valid = 1'b0;
        m_word[addr]  = data;
        m_valid[addr] = 1'b1;
    endtask

    task automatic write_pt_all();
        for (int i = 4; i < 8; i++) write_word(3'(i), $urandom);
    endtask

    // k in 1..TO: mock core answers on the k-th edge after WAIT entry; otherwise it never answers.
    task automatic run(input string tag, input int k, input logic [127:0] dout,
                       input bit hold, input logic [2:0] haddr, input logic [31:0] hdata);
        bit acc;
        acc = model_full();
        @(negedge clock);
        start = 1'b1;
        if (hold) begin
            wr_valid = 1'b1;
            wr_addr  = haddr;
            wr_data  = hdata;
        end
        #1 check({tag, ".wr_ready_start"}, wr_ready, 0);
        @(negedge clock);
        start = 1'b0;
        if (!acc) begin
            m_inc = 1'b1;
            check({tag, ".no_core_start"}, core_start, 0);
            check_state(tag);
            return;
        end
        m_done = 0;
        m_inc  = 0;
        m_to   = 0;
        for (int i = 4; i < 8; i++) m_valid[i] = 1'b0;
        check({tag, ".core_start"}, core_start, 1);
        check({tag, ".busy_start"}, busy, 1);
        check({tag, ".key_at_start"}, key_out, model_key());
        check({tag, ".pt_at_start"}, pt_out, model_pt());
        check({tag, ".flags_cleared"}, {done, err_incomplete, err_timeout}, 0);
        @(negedge clock);
        check({tag, ".core_start_width"}, core_start, 0);
        check({tag, ".busy_wait"}, busy, 1);
        for (int j = 1; j <= TO; j++) begin
            if (j == k) begin
                core_done = 1'b1;
                core_dout = dout;
            end
            @(negedge clock);
            core_done = 1'b0;
            core_dout = rand128();
            if (j == k) break;
            if (j == TO - 1) check({tag, ".busy_before_timeout"}, busy, 1);
            if (hold && j == 1) begin
                check({tag, ".wr_ready_busy"}, wr_ready, 0);
                check({tag, ".pt_stalled"}, pt_out, model_pt());
            end
        end
        if (k >= 1 && k <= TO) begin
            m_done = 1'b1;
            for (int i = 0; i < 4; i++) m_res[i] = 32'(dout >> (32 * (3 - i)));
        end else begin
            m_to = 1'b1;
        end
        check({tag, ".wr_ready_back"}, wr_ready, 1);
        if (hold) begin
            check({tag, ".key_held"}, key_out, model_key());
            check({tag, ".pt_held"}, pt_out, model_pt());
            @(negedge clock);
            wr_valid = 1'b0;
            m_word[haddr]  = hdata;
            m_valid[haddr] = 1'b1;
        end
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] fips_key;
        logic [127:0] fips_pt;
        logic [127:0] fips_ct;
        logic [31:0]  exp_ct [4];
        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
        fips_pt  = 128'h00112233445566778899aabbccddeeff;
        fips_ct  = 128'h69c4e0d86a7b0432d8cdb70480b4c55a;
        exp_ct   = '{32'h69c4e0d8, 32'h6a7b0432, 32'hd8cdb704, 32'h80b4c55a};

        reset = 1'b1;
        wr_valid = 0; wr_addr = 0; wr_data = 0; start = 0;
        rd_idx = 0; core_done = 0; core_dout = 0;
        model_reset();
        #5;
        check("reset.wr_ready", wr_ready, 1);
        check("reset.outputs", {busy, done, err_incomplete, err_timeout, core_start}, 0);
        check("reset.key_pt", {key_out, pt_out}, 0);
        check("reset.rd_data", rd_data, 0);
        @(negedge clock);
        reset = 1'b0;

        // FIPS-197 known-answer run with a 40-cycle mock core.
        for (int i = 0; i < 4; i++) write_word(3'(i), 32'(fips_key >> (32 * (3 - i))));
        for (int i = 0; i < 4; i++) write_word(3'(4 + i), 32'(fips_pt >> (32 * (3 - i))));
        check("fips.key_out", key_out, fips_key);
        check("fips.pt_out", pt_out, fips_pt);
        run("fips", 40, fips_ct, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1 check($sformatf("fips.ct[%0d]", i), rd_data, exp_ct[i]);
        end

        // Key reuse: only new plaintext words.
        write_pt_all();
        run("key_reuse", int'($urandom_range(1, 60)), rand128(), 0, 0, 0);

        // Three plaintext words only: rejected, done kept.
        for (int i = 4; i < 7; i++) write_word(3'(i), $urandom);
        run("incomplete", 5, rand128(), 0, 0, 0);

        // Complete the operand and let the core never answer.
        write_word(3'd7, $urandom);
        run("timeout", TO + 1, rand128(), 0, 0, 0);

        // Writes held through a start cycle and a run.
        write_pt_all();
        run("stall", 10, rand128(), 1, 3'd5, $urandom);
        write_pt_all();
        run("stall_key", 7, rand128(), 1, 3'd2, $urandom);

        // Completion on the same edge as the timeout.
        write_pt_all();
        run("done_vs_timeout", TO, rand128(), 0, 0, 0);

        // core_done while idle must not disturb the result.
        @(negedge clock);
        core_done = 1'b1;
        core_dout = rand128();
        @(negedge clock);
        core_done = 1'b0;
        check_state("idle_done");

        // Random operand traffic and core latencies.
        for (int it = 0; it < 12; it++) begin
            int nw;
            int k;
            nw = int'($urandom_range(0, 6));
            for (int w = 0; w < nw; w++) write_word(3'($urandom_range(0, 7)), $urandom);
            k = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(1, 60));
            run($sformatf("rand%0d", it), k, rand128(), 0, 0, 0);
        end

        // Reset in the middle of WAIT.
        for (int i = 0; i < 8; i++) write_word(3'(i), $urandom);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset.busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_reset.outputs", {busy, done, err_incomplete, err_timeout, core_start}, 0);
        check("mid_reset.key_pt", {key_out, pt_out}, 0);
        check("mid_reset.rd_data", rd_data, 0);
        check("mid_reset.wr_ready", wr_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        run("after_reset", 5, rand128(), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
